// File: rtl/fnd_display_arbiter.sv
// Round-robin owner arbitration for a shared 4-digit FND datapath, with a minimum hold in ticks.
// Optional macro FND_PREEMPT_EN: requester 0 preempts any other owner.
module fnd_display_arbiter #(
  parameter int          NUM_REQ    = 4,
  parameter int          MIN_HOLD   = 1000,
  parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       tick,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [16*NUM_REQ-1:0]      value_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic                       busy,
  output logic [15:0]                value_out
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int HW  = $clog2(MIN_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

  typedef enum logic {IDLE, OWN} state_t;

  state_t                    state_q, state_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d;
  logic [IDW-1:0]            owner_q, owner_d;
  logic                      busy_q, busy_d;
  logic [15:0]               value_q, value_d;
  logic [HW-1:0]             hold_q, hold_d;
  logic [IDW-1:0]            rr_q, rr_d;

  logic [NUM_REQ-1:0][15:0]  vals;
  logic [NUM_REQ-1:0]        cand;
  logic                      found, expired, do_grant, go_idle;
  logic [IDW-1:0]            pick, gidx;
  int                        scan_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign vals[i] = value_in[16*i +: 16];
  end

  // The current owner is masked out so rearbitration only ever picks someone else.
  assign cand    = req & ~gnt_q;
  assign expired = (hold_q == HOLD_MAX);

  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && cand[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    busy_d   = busy_q;
    value_d  = value_q;
    hold_d   = hold_q;
    rr_d     = rr_q;
    do_grant = 1'b0;
    go_idle  = 1'b0;
    gidx     = pick;

    unique case (state_q)
      IDLE: begin
        value_d = IDLE_VALUE;
        if (found) do_grant = 1'b1;
      end
      OWN: begin
        value_d = vals[owner_q];
        if (!req[owner_q]) begin
          if (found) do_grant = 1'b1;
          else       go_idle  = 1'b1;
        end else if (expired && found) begin
          do_grant = 1'b1;
        end else if (tick && !expired) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

`ifdef FND_PREEMPT_EN
    if (state_q == OWN && owner_q != '0 && req[0]) begin
      do_grant = 1'b1;
      go_idle  = 1'b0;
      gidx     = '0;
    end
`endif

    // A switch always restarts the hold window, so a coincident tick is dropped.
    if (go_idle) begin
      state_d = IDLE;
      gnt_d   = '0;
      owner_d = '0;
      busy_d  = 1'b0;
      value_d = IDLE_VALUE;
      hold_d  = '0;
    end else if (do_grant) begin
      state_d     = OWN;
      gnt_d       = '0;
      gnt_d[gidx] = 1'b1;
      owner_d     = gidx;
      busy_d      = 1'b1;
      hold_d      = '0;
      rr_d        = gidx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      value_q <= IDLE_VALUE;
      hold_q  <= '0;
      rr_q    <= IDW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      value_q <= value_d;
      hold_q  <= hold_d;
      rr_q    <= rr_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner_id  = owner_q;
  assign busy      = busy_q;
  assign value_out = value_q;
endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Directed bench for fnd_display_arbiter (NUM_REQ=4, MIN_HOLD=4) with an expectation queue.
module tb_fnd_display_arbiter;
  logic        clk = 1'b0, reset_n = 1'b0, tick = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] value_in = '0;
  logic [3:0]  gnt;
  logic [1:0]  owner_id;
  logic        busy;
  logic [15:0] value_out;
  int          tests = 0, fails = 0;

  typedef struct {
    string       tag;
    logic [3:0]  g;
    logic [1:0]  o;
    logic        b;
    logic [15:0] v;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  fnd_display_arbiter #(.NUM_REQ(4), .MIN_HOLD(4), .IDLE_VALUE(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .req(req), .value_in(value_in),
    .gnt(gnt), .owner_id(owner_id), .busy(busy), .value_out(value_out)
  );

  task automatic set_val(input int i, input logic [15:0] v);
    value_in[16*i +: 16] = v;
  endtask

  task automatic cmp1(input string tag, input string fld, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s.%s got %h expected %h", tag, fld, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] g, input logic [1:0] o, input logic b, input logic [15:0] v);
    exp_t e;
    e.tag = tag; e.g = g; e.o = o; e.b = b; e.v = v;
    sbq.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sbq.size() == 0) begin
      tests++; fails++;
      $error("FAIL scoreboard_empty got 0 entries expected 1");
      return;
    end
    e = sbq.pop_front();
    cmp1(e.tag, "gnt",   {12'h0, gnt},      {12'h0, e.g});
    cmp1(e.tag, "owner", {14'h0, owner_id}, {14'h0, e.o});
    cmp1(e.tag, "busy",  {15'h0, busy},     {15'h0, e.b});
    cmp1(e.tag, "value", value_out,         e.v);
  endtask

  // One clock: tick driven at the falling edge, outputs sampled 1 after the rising edge.
  task automatic step(input logic t, input string tag, input logic [3:0] g, input logic [1:0] o,
                      input logic b, input logic [15:0] v);
    push(tag, g, o, b, v);
    @(negedge clk) tick = t;
    @(posedge clk);
    #1;
    pop_chk();
  endtask

  task automatic own(input logic t, input string tag, input logic [3:0] g, input logic [1:0] o, input logic [15:0] v);
    step(t, tag, g, o, 1'b1, v);
  endtask

  task automatic idle(input string tag);
    step(1'b0, tag, 4'b0000, 2'd0, 1'b0, 16'h0000);
  endtask

  initial begin
    set_val(0, 16'hAAAA); set_val(1, 16'h0042); set_val(2, 16'h1234); set_val(3, 16'h3333);
    #12;
    push("reset", 4'b0000, 2'd0, 1'b0, 16'h0000);
    pop_chk();
    @(negedge clk) reset_n = 1'b1;
    repeat (3) idle("idle_hold");

    // Single requester 2, then 0 and 1 join and wait for expiry.
    req = 4'b0100;
    own(1'b0, "grant2", 4'b0100, 2'd2, 16'h0000);
    own(1'b0, "val2", 4'b0100, 2'd2, 16'h1234);
    req = 4'b0111;
    own(1'b1, "hold2_t1", 4'b0100, 2'd2, 16'h1234);
    own(1'b0, "hold2", 4'b0100, 2'd2, 16'h1234);
    own(1'b1, "hold2_t2", 4'b0100, 2'd2, 16'h1234);
    own(1'b0, "hold2", 4'b0100, 2'd2, 16'h1234);
    own(1'b1, "hold2_t3", 4'b0100, 2'd2, 16'h1234);
    own(1'b0, "hold2", 4'b0100, 2'd2, 16'h1234);
    own(1'b1, "hold2_t4", 4'b0100, 2'd2, 16'h1234);
    own(1'b0, "rr_to0", 4'b0001, 2'd0, 16'h1234);
    own(1'b0, "val0", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b1, "hold0_t1", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b0, "hold0", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b1, "hold0_t2", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b0, "hold0", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b1, "hold0_t3", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b0, "hold0", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b1, "hold0_t4", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b1, "rr_to1_tick", 4'b0010, 2'd1, 16'hAAAA);

    // Live value tracking, then owner drop with requester 3 pending.
    own(1'b0, "val1", 4'b0010, 2'd1, 16'h0042);
    set_val(1, 16'h0043);
    own(1'b0, "val1_live", 4'b0010, 2'd1, 16'h0043);
    own(1'b1, "hold1_t1", 4'b0010, 2'd1, 16'h0043);
    req = 4'b1001;
    own(1'b0, "drop_to3", 4'b1000, 2'd3, 16'h0043);
    own(1'b0, "val3", 4'b1000, 2'd3, 16'h3333);

    // Owner 3 expires; switch edge carries a tick that must not count.
    own(1'b1, "hold3_t1", 4'b1000, 2'd3, 16'h3333);
    own(1'b0, "hold3", 4'b1000, 2'd3, 16'h3333);
    own(1'b1, "hold3_t2", 4'b1000, 2'd3, 16'h3333);
    own(1'b0, "hold3", 4'b1000, 2'd3, 16'h3333);
    own(1'b1, "hold3_t3", 4'b1000, 2'd3, 16'h3333);
    own(1'b0, "hold3", 4'b1000, 2'd3, 16'h3333);
    own(1'b1, "hold3_t4", 4'b1000, 2'd3, 16'h3333);
    own(1'b1, "wrap_to0_tick", 4'b0001, 2'd0, 16'h3333);
    own(1'b0, "val0b", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b1, "hold0b_t1", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b0, "hold0b", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b1, "hold0b_t2", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b0, "hold0b", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b1, "hold0b_t3", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b0, "tick_not_counted", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b1, "hold0b_t4", 4'b0001, 2'd0, 16'hAAAA);
    own(1'b0, "rr_to3", 4'b1000, 2'd3, 16'hAAAA);
    req = 4'b0000;
    idle("drop_idle");
    idle("idle_again");

    // Request glitch between edges is never granted.
    req = 4'b0010;
    #2 req = 4'b0000;
    idle("glitch");

    // Preemption by requester 0 while 2 is inside its hold window.
    req = 4'b0100;
    own(1'b0, "grant2b", 4'b0100, 2'd2, 16'h0000);
    own(1'b1, "hold2b_t1", 4'b0100, 2'd2, 16'h1234);
    req = 4'b0101;
`ifdef FND_PREEMPT_EN
    own(1'b0, "preempt0", 4'b0001, 2'd0, 16'h1234);
`else
    own(1'b0, "no_preempt", 4'b0100, 2'd2, 16'h1234);
    own(1'b1, "hold2b_t2", 4'b0100, 2'd2, 16'h1234);
    own(1'b0, "hold2b", 4'b0100, 2'd2, 16'h1234);
    own(1'b1, "hold2b_t3", 4'b0100, 2'd2, 16'h1234);
    own(1'b0, "hold2b", 4'b0100, 2'd2, 16'h1234);
    own(1'b1, "hold2b_t4", 4'b0100, 2'd2, 16'h1234);
    own(1'b0, "rr2_to0", 4'b0001, 2'd0, 16'h1234);
`endif

    // Asynchronous reset mid-ownership, then the first grant favors requester 0.
    reset_n = 1'b0;
    #1;
    push("async_reset", 4'b0000, 2'd0, 1'b0, 16'h0000);
    pop_chk();
    req = 4'b1111;
    idle("in_reset");
    reset_n = 1'b1;
    own(1'b0, "post_reset0", 4'b0001, 2'd0, 16'h0000);
    req = 4'b0001;
    own(1'b0, "sat_val0", 4'b0001, 2'd0, 16'hAAAA);
    repeat (10) own(1'b1, "saturate", 4'b0001, 2'd0, 16'hAAAA);
    req = 4'b0011;
    own(1'b0, "expired_to1", 4'b0010, 2'd1, 16'hAAAA);
    own(1'b0, "val1b", 4'b0010, 2'd1, 16'h0043);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
